// File: rtl/simple_pipe_pkg.sv
// Shared definitions for the simple 4-register ADD/SUB/AND pipeline and its
// instruction issue queue: word width, opcodes and field-slice helpers.
package simple_pipe_pkg;

  localparam int INST_W = 8;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_AND = 2'b11
  } op_e;

  // All-zero word decodes as OP_NOP with every register field zero.
  localparam logic [INST_W-1:0] NOP_INST = 8'h00;

  function automatic op_e inst_op(input logic [INST_W-1:0] i);
    return op_e'(i[7:6]);
  endfunction

  function automatic logic [1:0] inst_rs1(input logic [INST_W-1:0] i);
    return i[5:4];
  endfunction

  function automatic logic [1:0] inst_rs2(input logic [INST_W-1:0] i);
    return i[3:2];
  endfunction

  function automatic logic [1:0] inst_rd(input logic [INST_W-1:0] i);
    return i[1:0];
  endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// Producer-side valid/ready handshake carrying one instruction word.
interface inst_issue_queue_if
  import simple_pipe_pkg::*;
  ;
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;

  // Producer drives the offer and watches for room.
  modport master (output in_valid, output in_inst, input in_ready);
  // Queue accepts the offer and advertises room.
  modport slave  (input in_valid, input in_inst, output in_ready);

endinterface

// File: rtl/inst_queue_mem.sv
// DEPTH x INST_W register array: one synchronous write port, one
// asynchronous (combinational) read port. Holds no control state.
module inst_queue_mem
  import simple_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem [DEPTH];

  // Capture the pushed word into the slot addressed by the write pointer.
  // NOTE: the array has no reset; stale contents are never visible because
  // the read side is masked by occupancy in the parent, and leaving it
  // unreset lets it map onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction issue queue in front of the ADD/SUB/AND pipeline. Buffers
// producer instructions, presents the head on `inst` (NOP bubble when empty),
// pops on `run`, and tracks issue/bubble counts plus a sticky drop flag.
module inst_issue_queue
  import simple_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_issue_queue_if.slave        in_if,
  input  logic                     run,
  input  logic                     flush,
  output logic [INST_W-1:0]        inst,
  output logic                     inst_valid,
  output logic [7:0]               issued_cnt,
  output logic [7:0]               bubble_cnt,
  output logic                     drop_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [INST_W-1:0] head;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              bubble;

  // Ready and head validity come from registered occupancy only, so the
  // producer never sees a combinational path from `run`.
  assign not_empty      = (count != '0);
  assign in_if.in_ready = (count != FULL_CNT);

  // Flush wins over both push and pop; an empty queue never pops.
  assign push   = in_if.in_valid && in_if.in_ready && !flush;
  assign pop    = run && not_empty && !flush;
  assign bubble = run && !not_empty && !flush;

  inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (in_if.in_inst),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // No bypass: an entry pushed into an empty queue shows up one cycle later.
  assign inst       = not_empty ? head : NOP_INST;
  assign inst_valid = not_empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue and bubble statistics; both wrap at 8'hFF and are already
  // qualified by !flush through pop/bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (pop)    issued_cnt <= issued_cnt + 8'd1;
      if (bubble) bubble_cnt <= bubble_cnt + 8'd1;
    end
  end

  // Sticky record of any offer made while the queue was full; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    drop_err <= 1'b0;
    else if (in_if.in_valid && !in_if.in_ready) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: a vector table for the basic
// fill/overflow/drain flow, then hand-written multi-cycle corner cases.
module tb_inst_issue_queue;
  import simple_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic flush;
  logic [7:0] inst;
  logic inst_valid;
  logic [7:0] issued_cnt;
  logic [7:0] bubble_cnt;
  logic drop_err;

  inst_issue_queue_if bus ();

  inst_issue_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .run        (run),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .issued_cnt (issued_cnt),
    .bubble_cnt (bubble_cnt),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are checked
  // mid-cycle, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    bus.in_valid = v;
    bus.in_inst  = d;
    run          = r;
    flush        = f;
  endtask

  task automatic check_head(input string tag, input logic [7:0] e_inst,
                            input logic e_iv, input logic e_rdy);
    #1;
    check({tag, ".inst"},       {24'd0, inst},          {24'd0, e_inst});
    check({tag, ".inst_valid"}, {31'd0, inst_valid},    {31'd0, e_iv});
    check({tag, ".in_ready"},   {31'd0, bus.in_ready},  {31'd0, e_rdy});
  endtask

  task automatic check_stats(input string tag, input logic [7:0] e_iss,
                             input logic [7:0] e_bub, input logic e_drop);
    check({tag, ".issued_cnt"}, {24'd0, issued_cnt}, {24'd0, e_iss});
    check({tag, ".bubble_cnt"}, {24'd0, bubble_cnt}, {24'd0, e_bub});
    check({tag, ".drop_err"},   {31'd0, drop_err},   {31'd0, e_drop});
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One vector: inputs held for one cycle; expectations are the outputs seen
  // during that cycle, before the edge that consumes the inputs.
  typedef struct {
    logic       in_valid;
    logic [7:0] in_inst;
    logic       run;
    logic       flush;
    logic [7:0] e_inst;
    logic       e_iv;
    logic       e_rdy;
    logic [7:0] e_iss;
    logic [7:0] e_bub;
    logic       e_drop;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;

    //            v     data   run   fl    inst   iv    rdy   iss   bub   drop
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'd2, 1'b0};
    // three bubbles done; fill with run low
    vecs[3]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'd3, 1'b0};
    vecs[4]  = '{1'b1, 8'h86, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0};
    vecs[5]  = '{1'b1, 8'hC7, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0};
    vecs[6]  = '{1'b1, 8'h4B, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 8'd0, 8'd3, 1'b0};
    // full: fifth offer is dropped
    vecs[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0};
    // drain in order, then one bubble (bubble count goes 3 -> 4)
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h86, 1'b1, 1'b1, 8'd1, 8'd3, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hC7, 1'b1, 1'b1, 8'd2, 8'd3, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h4B, 1'b1, 1'b1, 8'd3, 8'd3, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd4, 8'd3, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd4, 8'd4, 1'b1};

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].in_valid, vecs[i].in_inst, vecs[i].run, vecs[i].flush);
      check_head(tag, vecs[i].e_inst, vecs[i].e_iv, vecs[i].e_rdy);
      check_stats(tag, vecs[i].e_iss, vecs[i].e_bub, vecs[i].e_drop);
      tick();
    end

    // ---- full queue, push offered on the same edge as a pop ----
    do_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h44, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    check_head("fullpop.pre", 8'h11, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check_head("fullpop.post", 8'h22, 1'b1, 1'b1);
    check_stats("fullpop.post", 8'd1, 8'd0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_head("fullpop.refill", 8'h22, 1'b1, 1'b0);
    tick(); check_head("fullpop.d1", 8'h33, 1'b1, 1'b1);
    tick(); check_head("fullpop.d2", 8'h44, 1'b1, 1'b1);
    tick(); check_head("fullpop.d3", 8'hAA, 1'b1, 1'b1);
    tick(); check_head("fullpop.empty", 8'h00, 1'b0, 1'b1);
    check_stats("fullpop.empty", 8'd5, 8'd0, 1'b1);
    // empty + push + run: bubble now, entry visible next cycle, then stream
    drive(1'b1, 8'hBB, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hCC, 1'b1, 1'b0);
    check_head("stream.first", 8'hBB, 1'b1, 1'b1);
    check_stats("stream.first", 8'd5, 8'd1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_head("stream.second", 8'hCC, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_head("stream.done", 8'h00, 1'b0, 1'b1);
    check_stats("stream.done", 8'd7, 8'd1, 1'b1);

    // ---- flush with push and run on the same edge ----
    do_reset();
    drive(1'b1, 8'h5A, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h6B, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h7C, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    check_head("flush.pre", 8'h5A, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_head("flush.post", 8'h00, 1'b0, 1'b1);
    check_stats("flush.post", 8'd0, 8'd0, 1'b0);
    tick();
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    check_stats("flush.bubble", 8'd0, 8'd1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_head("flush.repush", 8'h33, 1'b1, 1'b1);

    // ---- asynchronous reset mid-stream ----
    do_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h03, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h04, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h05, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b1, 8'h06, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h07, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h08, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_head("midrst.before", 8'h07, 1'b1, 1'b1);
    check_stats("midrst.before", 8'd5, 8'd0, 1'b1);
    #2;
    rst = 1'b1;
    check_head("midrst.async", 8'h00, 1'b0, 1'b1);
    check_stats("midrst.async", 8'd0, 8'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h9A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_head("midrst.resume", 8'h9A, 1'b1, 1'b1);
    check_stats("midrst.resume", 8'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
